random_logic: RTL and testbench

RANDOM_LOGIC -- requirements
Module: random_logic

---
 rtl/random_logic_pkg.sv | 76 +++++++
 rtl/random_logic_sodet.sv | 14 +
 rtl/random_logic.sv | 105 ++++++++++
 tb/tb_random_logic.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/random_logic_pkg.sv
// random_logic_pkg: PLA line width, per-control decode masks and timing qualifiers.
package random_logic_pkg;
    localparam int DEC_W = 130;
    typedef logic [DEC_W-1:0] mask_t;
    typedef enum logic [2:0] {TQ_ANY, TQ_T0, TQ_T1, TQ_T5, TQ_T6} tq_e;
    typedef struct packed {
        mask_t m;
        tq_e   q;
    } ctl_t;
    function automatic mask_t ln(input int n);
        return mask_t'(1) << n;
    endfunction
    // T6 qualifies like T5 so BRK sequencing fires in either cycle
    function automatic logic fire(input ctl_t c, input mask_t d, input logic [3:0] t);
        logic q;
        q = (c.q == TQ_T0) ? t[0] : (c.q == TQ_T1) ? t[1] : (c.q == TQ_T5 || c.q == TQ_T6) ? |t[3:2] : 1'b1;
        return |(d & c.m) & q;
    endfunction
    localparam ctl_t C_Y_SB     = '{ln(0) | ln(1), TQ_ANY};
    localparam ctl_t C_X_SB     = '{ln(2) | ln(3), TQ_ANY};
    localparam ctl_t C_SB_Y     = '{ln(4), TQ_ANY};
    localparam ctl_t C_SB_X     = '{ln(5), TQ_ANY};
    localparam ctl_t C_S_SB     = '{ln(6), TQ_ANY};
    localparam ctl_t C_S_ADL    = '{ln(7), TQ_ANY};
    localparam ctl_t C_SB_S     = '{ln(8), TQ_ANY};
    localparam ctl_t C_S_S      = '{ln(9), TQ_ANY};
    localparam ctl_t C_AC_SB    = '{ln(10), TQ_ANY};
    localparam ctl_t C_AC_DB    = '{ln(11), TQ_ANY};
    localparam ctl_t C_SB_AC    = '{ln(12), TQ_ANY};
    localparam ctl_t C_SB_DB    = '{ln(13), TQ_ANY};
    localparam ctl_t C_SB_ADH   = '{ln(14), TQ_ANY};
    localparam ctl_t C_Z_ADH0   = '{ln(15), TQ_ANY};
    localparam ctl_t C_Z_ADH17  = '{ln(16), TQ_ANY};
    localparam ctl_t C_NDB_ADD  = '{ln(17), TQ_ANY};
    localparam ctl_t C_DB_ADD   = '{ln(18) | ln(101), TQ_ANY};
    localparam ctl_t C_Z_ADD    = '{ln(19), TQ_ANY};
    localparam ctl_t C_SB_ADD   = '{ln(20), TQ_ANY};
    localparam ctl_t C_ADL_ADD  = '{ln(21), TQ_ANY};
    localparam ctl_t C_ANDS     = '{ln(22), TQ_ANY};
    localparam ctl_t C_EORS     = '{ln(23), TQ_ANY};
    localparam ctl_t C_ORS      = '{ln(24), TQ_ANY};
    localparam ctl_t C_SRS      = '{ln(25), TQ_ANY};
    localparam ctl_t C_SUMS     = '{ln(26) | ln(27) | ln(28) | ln(101), TQ_ANY};
    localparam ctl_t C_ADD_SB7  = '{ln(29), TQ_ANY};
    localparam ctl_t C_ADD_SB06 = '{ln(30), TQ_ANY};
    localparam ctl_t C_ADD_ADL  = '{ln(31), TQ_ANY};
    localparam ctl_t C_CARRY    = '{ln(27) | ln(28), TQ_ANY};
    localparam ctl_t C_INC      = '{ln(32), TQ_ANY};
    localparam ctl_t C_ADC      = '{ln(27), TQ_ANY};
    localparam ctl_t C_SBC      = '{ln(28), TQ_ANY};
    localparam ctl_t C_PCL_DB   = '{ln(33), TQ_ANY};
    localparam ctl_t C_PCH_DB   = '{ln(34), TQ_ANY};
    localparam ctl_t C_ADL_PCL  = '{ln(35) | ln(98), TQ_ANY};
    localparam ctl_t C_ADH_PCH  = '{ln(36), TQ_ANY};
    localparam ctl_t C_PCL_ADL  = '{ln(37), TQ_ANY};
    localparam ctl_t C_PCH_ADH  = '{ln(38), TQ_ANY};
    localparam ctl_t C_DL_DB    = '{ln(40), TQ_ANY};
    localparam ctl_t C_ADH_ABH  = '{ln(41), TQ_ANY};
    localparam ctl_t C_ADL_ABL  = '{ln(42), TQ_ANY};
    localparam ctl_t C_DL_ADL   = '{ln(43), TQ_ANY};
    localparam ctl_t C_DL_ADH   = '{ln(44), TQ_ANY};
    localparam ctl_t C_P_DB     = '{ln(45), TQ_ANY};
    localparam ctl_t C_ACR_C    = '{ln(46), TQ_ANY};
    localparam ctl_t C_AVR_V    = '{ln(47), TQ_ANY};
    localparam ctl_t C_DBZ_Z    = '{ln(48), TQ_ANY};
    localparam ctl_t C_DB_N     = '{ln(49), TQ_ANY};
    localparam ctl_t C_DB_P     = '{ln(50), TQ_ANY};
    localparam ctl_t C_DB_C     = '{ln(51), TQ_ANY};
    localparam ctl_t C_DB_V     = '{ln(52), TQ_ANY};
    localparam ctl_t C_IR5_C    = '{ln(53), TQ_ANY};
    localparam ctl_t C_IR5_I    = '{ln(54), TQ_ANY};
    localparam ctl_t C_IR5_D    = '{ln(55), TQ_ANY};
    localparam ctl_t C_ZERO_V   = '{ln(56), TQ_ANY};
    localparam ctl_t C_BRK5     = '{ln(57), TQ_T5};
    localparam ctl_t C_BR2      = '{ln(58), TQ_T0};
endpackage

// File: rtl/random_logic_sodet.sv
// random_logic_sodet: rising-edge detector for the set-overflow pin.
module random_logic_sodet (
    input  logic PHI0,
    input  logic RST,
    input  logic SO,
    output logic rise
);
    logic so_q;
    always_ff @(posedge PHI0 or posedge RST) begin
        if (RST) so_q <= 1'b0;
        else so_q <= SO;
    end
    assign rise = SO & ~so_q;
endmodule

// File: rtl/random_logic.sv
// random_logic: registered random-control decode from PLA lines and timing flags.
module random_logic #(
    parameter int DEC_W = random_logic_pkg::DEC_W
) (
    input  logic             PHI0,
    input  logic             RST,
    input  logic [DEC_W-1:0] decoder,
    input  logic             T0, T1, T5, T6,
    input  logic             RDY, _ready,
    input  logic             BRK6E, Z_ADL0, SO, BRFW, ACRL2,
    input  logic             _C_OUT, _D_OUT,
    output logic             BRK5, BR2,
    output logic             Y_SB, X_SB, SB_Y, SB_X, S_SB, S_ADL, SB_S, S_S,
    output logic             AC_SB, AC_DB, SB_AC, SB_DB, SB_ADH, Z_ADH0, Z_ADH17,
    output logic             NDB_ADD, DB_ADD, Z_ADD, SB_ADD, ADL_ADD, ANDS, EORS, ORS, SRS, SUMS,
    output logic             ADD_SB7, ADD_SB06, ADD_ADL, _ADDC, _DAA, _DSA,
    output logic             PC_DB, _ADL_PCL, ADL_PCL, PCL_PCL, PCL_ADL, PCL_DB, ADH_PCH, PCH_PCH,
    output logic             PCH_ADH, PCH_DB, ADH_ABH, ADL_ABL, DL_ADL, DL_ADH, DL_DB,
    output logic             P_DB, ACR_C, AVR_V, DBZ_Z, DB_N, DB_P, DB_C, DB_V,
    output logic             IR5_C, IR5_I, IR5_D, ZERO_V, ONE_V
);
    import random_logic_pkg::*;
    mask_t      d;
    logic [3:0] t;
    logic       run, so_rise;
    logic [4:0] alu_raw, alu_sel;
    assign d = mask_t'(decoder);
    assign t = {T6, T5, T1, T0};
    assign run = RDY & ~_ready;
    assign alu_raw = {fire(C_SRS, d, t), fire(C_ORS, d, t), fire(C_EORS, d, t), fire(C_ANDS, d, t), fire(C_SUMS, d, t)};
    // keep only the lowest set bit; SUMS sits at bit 0 so it outranks the logic ops
    assign alu_sel = alu_raw & (~alu_raw + 5'd1);
    assign PCL_PCL = ~ADL_PCL;
    assign _ADL_PCL = ~ADL_PCL;
    assign PCH_PCH = ~ADH_PCH;
    assign PC_DB = PCL_DB | PCH_DB;
    random_logic_sodet u_sodet (.PHI0(PHI0), .RST(RST), .SO(SO), .rise(so_rise));
    always_ff @(posedge PHI0 or posedge RST) begin
        if (RST) begin
            {BRK5, BR2, Y_SB, X_SB, SB_Y, SB_X, S_SB, S_ADL, SB_S, S_S, AC_SB, AC_DB, SB_AC, SB_DB,
             SB_ADH, Z_ADH0, Z_ADH17, NDB_ADD, DB_ADD, Z_ADD, SB_ADD, ADL_ADD, ANDS, EORS, ORS, SRS,
             SUMS, ADD_SB7, ADD_SB06, ADD_ADL, ADL_PCL, PCL_ADL, PCL_DB, ADH_PCH, PCH_ADH, PCH_DB,
             DL_ADL, DL_ADH, DL_DB, P_DB, ACR_C, AVR_V, DBZ_Z, DB_N, DB_P, DB_C, DB_V, IR5_C, IR5_I,
             IR5_D, ZERO_V, ONE_V} <= '0;
            {ADH_ABH, ADL_ABL, _ADDC, _DAA, _DSA} <= '1;
        end else if (run) begin
            BRK5     <= fire(C_BRK5, d, t);
            BR2      <= fire(C_BR2, d, t);
            Y_SB     <= fire(C_Y_SB, d, t);
            X_SB     <= fire(C_X_SB, d, t);
            SB_Y     <= fire(C_SB_Y, d, t);
            SB_X     <= fire(C_SB_X, d, t);
            S_SB     <= fire(C_S_SB, d, t);
            S_ADL    <= fire(C_S_ADL, d, t);
            SB_S     <= fire(C_SB_S, d, t);
            S_S      <= fire(C_S_S, d, t);
            AC_SB    <= fire(C_AC_SB, d, t);
            AC_DB    <= fire(C_AC_DB, d, t);
            SB_AC    <= fire(C_SB_AC, d, t);
            SB_DB    <= fire(C_SB_DB, d, t);
            SB_ADH   <= fire(C_SB_ADH, d, t);
            Z_ADH0   <= fire(C_Z_ADH0, d, t) | Z_ADL0;
            Z_ADH17  <= fire(C_Z_ADH17, d, t);
            NDB_ADD  <= fire(C_NDB_ADD, d, t);
            DB_ADD   <= fire(C_DB_ADD, d, t);
            Z_ADD    <= fire(C_Z_ADD, d, t);
            SB_ADD   <= fire(C_SB_ADD, d, t);
            ADL_ADD  <= fire(C_ADL_ADD, d, t);
            {SUMS, ANDS, EORS, ORS, SRS} <= {alu_sel[0], alu_sel[1], alu_sel[2], alu_sel[3], alu_sel[4]};
            ADD_SB7  <= fire(C_ADD_SB7, d, t);
            ADD_SB06 <= fire(C_ADD_SB06, d, t);
            ADD_ADL  <= fire(C_ADD_ADL, d, t);
            _ADDC    <= ~((fire(C_CARRY, d, t) & ~_C_OUT) | fire(C_INC, d, t));
            _DAA     <= ~(fire(C_ADC, d, t) & ~_D_OUT);
            _DSA     <= ~(fire(C_SBC, d, t) & ~_D_OUT);
            ADL_PCL  <= fire(C_ADL_PCL, d, t) & ~T1;
            ADH_PCH  <= (fire(C_ADH_PCH, d, t) & ~T1) | (BR2 & ~BRFW & ACRL2);
            PCL_ADL  <= fire(C_PCL_ADL, d, t);
            PCL_DB   <= fire(C_PCL_DB, d, t);
            PCH_ADH  <= fire(C_PCH_ADH, d, t);
            PCH_DB   <= fire(C_PCH_DB, d, t);
            ADH_ABH  <= ~fire(C_ADH_ABH, d, t);
            ADL_ABL  <= ~fire(C_ADL_ABL, d, t);
            DL_ADL   <= fire(C_DL_ADL, d, t) | BRK6E;
            DL_ADH   <= fire(C_DL_ADH, d, t) | BRK6E;
            DL_DB    <= fire(C_DL_DB, d, t) | T1;
            P_DB     <= fire(C_P_DB, d, t);
            ACR_C    <= fire(C_ACR_C, d, t);
            AVR_V    <= fire(C_AVR_V, d, t) & ~so_rise;
            DBZ_Z    <= fire(C_DBZ_Z, d, t);
            DB_N     <= fire(C_DB_N, d, t);
            DB_P     <= fire(C_DB_P, d, t);
            DB_C     <= fire(C_DB_C, d, t);
            DB_V     <= fire(C_DB_V, d, t);
            IR5_C    <= fire(C_IR5_C, d, t);
            IR5_I    <= fire(C_IR5_I, d, t);
            IR5_D    <= fire(C_IR5_D, d, t);
            ZERO_V   <= fire(C_ZERO_V, d, t) & ~so_rise;
            ONE_V    <= so_rise;
        end else begin
            ADH_ABH <= 1'b1;
            ADL_ABL <= 1'b1;
        end
    end
endmodule

// File: tb/tb_random_logic.sv
// tb_random_logic: scoreboard bench for random_logic control decode.
module tb_random_logic;
    typedef logic [129:0] dec_t;
    typedef struct packed {
        logic BRK5, BR2, Y_SB, X_SB, SB_Y, SB_X, S_SB, S_ADL, SB_S, S_S, AC_SB, AC_DB, SB_AC, SB_DB, SB_ADH, Z_ADH0, Z_ADH17;
        logic NDB_ADD, DB_ADD, Z_ADD, SB_ADD, ADL_ADD, ANDS, EORS, ORS, SRS, SUMS, ADD_SB7, ADD_SB06, ADD_ADL, _ADDC, _DAA, _DSA;
        logic PC_DB, _ADL_PCL, ADL_PCL, PCL_PCL, PCL_ADL, PCL_DB, ADH_PCH, PCH_PCH, PCH_ADH, PCH_DB, ADH_ABH, ADL_ABL, DL_ADL, DL_ADH, DL_DB;
        logic P_DB, ACR_C, AVR_V, DBZ_Z, DB_N, DB_P, DB_C, DB_V, IR5_C, IR5_I, IR5_D, ZERO_V, ONE_V;
    } out_t;

    logic PHI0 = 1'b0, RST;
    dec_t decoder;
    logic T0, T1, T5, T6, RDY, _ready, BRK6E, Z_ADL0, SO, BRFW, ACRL2, _C_OUT, _D_OUT;
    logic BRK5, BR2, Y_SB, X_SB, SB_Y, SB_X, S_SB, S_ADL, SB_S, S_S, AC_SB, AC_DB, SB_AC, SB_DB, SB_ADH, Z_ADH0, Z_ADH17;
    logic NDB_ADD, DB_ADD, Z_ADD, SB_ADD, ADL_ADD, ANDS, EORS, ORS, SRS, SUMS, ADD_SB7, ADD_SB06, ADD_ADL, _ADDC, _DAA, _DSA;
    logic PC_DB, _ADL_PCL, ADL_PCL, PCL_PCL, PCL_ADL, PCL_DB, ADH_PCH, PCH_PCH, PCH_ADH, PCH_DB, ADH_ABH, ADL_ABL, DL_ADL, DL_ADH, DL_DB;
    logic P_DB, ACR_C, AVR_V, DBZ_Z, DB_N, DB_P, DB_C, DB_V, IR5_C, IR5_I, IR5_D, ZERO_V, ONE_V;
    out_t o, want;
    out_t exp_q[$];
    int checks = 0, errors = 0;

    assign o = {BRK5, BR2, Y_SB, X_SB, SB_Y, SB_X, S_SB, S_ADL, SB_S, S_S, AC_SB, AC_DB, SB_AC, SB_DB, SB_ADH, Z_ADH0, Z_ADH17,
                NDB_ADD, DB_ADD, Z_ADD, SB_ADD, ADL_ADD, ANDS, EORS, ORS, SRS, SUMS, ADD_SB7, ADD_SB06, ADD_ADL, _ADDC, _DAA, _DSA,
                PC_DB, _ADL_PCL, ADL_PCL, PCL_PCL, PCL_ADL, PCL_DB, ADH_PCH, PCH_PCH, PCH_ADH, PCH_DB, ADH_ABH, ADL_ABL, DL_ADL, DL_ADH, DL_DB,
                P_DB, ACR_C, AVR_V, DBZ_Z, DB_N, DB_P, DB_C, DB_V, IR5_C, IR5_I, IR5_D, ZERO_V, ONE_V};

    random_logic #(.DEC_W(130)) dut (
        .PHI0(PHI0), .RST(RST), .decoder(decoder), .T0(T0), .T1(T1), .T5(T5), .T6(T6),
        .RDY(RDY), ._ready(_ready), .BRK6E(BRK6E), .Z_ADL0(Z_ADL0), .SO(SO), .BRFW(BRFW), .ACRL2(ACRL2),
        ._C_OUT(_C_OUT), ._D_OUT(_D_OUT), .BRK5(BRK5), .BR2(BR2),
        .Y_SB(Y_SB), .X_SB(X_SB), .SB_Y(SB_Y), .SB_X(SB_X), .S_SB(S_SB), .S_ADL(S_ADL), .SB_S(SB_S), .S_S(S_S),
        .AC_SB(AC_SB), .AC_DB(AC_DB), .SB_AC(SB_AC), .SB_DB(SB_DB), .SB_ADH(SB_ADH), .Z_ADH0(Z_ADH0), .Z_ADH17(Z_ADH17),
        .NDB_ADD(NDB_ADD), .DB_ADD(DB_ADD), .Z_ADD(Z_ADD), .SB_ADD(SB_ADD), .ADL_ADD(ADL_ADD), .ANDS(ANDS), .EORS(EORS),
        .ORS(ORS), .SRS(SRS), .SUMS(SUMS), .ADD_SB7(ADD_SB7), .ADD_SB06(ADD_SB06), .ADD_ADL(ADD_ADL),
        ._ADDC(_ADDC), ._DAA(_DAA), ._DSA(_DSA), .PC_DB(PC_DB), ._ADL_PCL(_ADL_PCL), .ADL_PCL(ADL_PCL),
        .PCL_PCL(PCL_PCL), .PCL_ADL(PCL_ADL), .PCL_DB(PCL_DB), .ADH_PCH(ADH_PCH), .PCH_PCH(PCH_PCH),
        .PCH_ADH(PCH_ADH), .PCH_DB(PCH_DB), .ADH_ABH(ADH_ABH), .ADL_ABL(ADL_ABL), .DL_ADL(DL_ADL),
        .DL_ADH(DL_ADH), .DL_DB(DL_DB), .P_DB(P_DB), .ACR_C(ACR_C), .AVR_V(AVR_V), .DBZ_Z(DBZ_Z),
        .DB_N(DB_N), .DB_P(DB_P), .DB_C(DB_C), .DB_V(DB_V), .IR5_C(IR5_C), .IR5_I(IR5_I), .IR5_D(IR5_D),
        .ZERO_V(ZERO_V), .ONE_V(ONE_V)
    );

    always #5 PHI0 = ~PHI0;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    function automatic dec_t line(input int k);
        return dec_t'(1) << k;
    endfunction

    function automatic out_t idle();
        out_t e = '0;
        e.PCL_PCL = 1'b1; e.PCH_PCH = 1'b1; e.ADH_ABH = 1'b1; e.ADL_ABL = 1'b1;
        e._ADL_PCL = 1'b1; e._ADDC = 1'b1; e._DAA = 1'b1; e._DSA = 1'b1;
        return e;
    endfunction

    task automatic test_reset();
        #1;
        checks++;
        if (o !== idle()) begin errors++; $display("FAIL reset_async: got %h want %h", o, idle()); end
        decoder = '1;
        @(posedge PHI0); @(negedge PHI0);
        checks++;
        if (o !== idle()) begin errors++; $display("FAIL reset_held: got %h want %h", o, idle()); end
        decoder = '0;
        RST = 1'b0;
        exp_q.push_back(idle());
        @(posedge PHI0); @(negedge PHI0);
        want = exp_q.pop_front();
        checks++;
        if (o !== want) begin errors++; $display("FAIL reset_release: got %h want %h", o, want); end
    endtask

    task automatic test_mask();
        out_t e = idle();
        e.SB_S = 1'b1; e.ADL_PCL = 1'b1; e._ADL_PCL = 1'b0; e.PCL_PCL = 1'b0; e.SUMS = 1'b1; e.DB_ADD = 1'b1;
        decoder = line(8) | line(98) | line(101);
        #1;
        checks++;
        if (o !== idle()) begin errors++; $display("FAIL mask_comb_path: got %h want %h", o, idle()); end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(e);
            @(posedge PHI0); @(negedge PHI0);
            want = exp_q.pop_front();
            checks++;
            if (o !== want) begin errors++; $display("FAIL mask[%0d]: got %h want %h", i, o, want); end
        end
        decoder = '0;
    endtask

    task automatic test_alu_priority();
        dec_t dv[5];
        out_t ev[5];
        dv[0] = line(22) | line(23) | line(24) | line(25) | line(26);
        dv[1] = line(22) | line(23) | line(24) | line(25);
        dv[2] = line(23) | line(24) | line(25);
        dv[3] = line(24) | line(25);
        dv[4] = line(25);
        for (int i = 0; i < 5; i++) ev[i] = idle();
        ev[0].SUMS = 1'b1; ev[1].ANDS = 1'b1; ev[2].EORS = 1'b1; ev[3].ORS = 1'b1; ev[4].SRS = 1'b1;
        for (int i = 0; i < 5; i++) begin
            decoder = dv[i];
            exp_q.push_back(ev[i]);
            @(posedge PHI0); @(negedge PHI0);
            want = exp_q.pop_front();
            checks++;
            if (o !== want) begin errors++; $display("FAIL alu_prio[%0d]: got %h want %h", i, o, want); end
        end
        decoder = '0;
    endtask

    task automatic test_rdy_hold();
        dec_t dv[5];
        logic rv[5], nv[5];
        out_t ev[5];
        out_t frozen = idle();
        frozen.Y_SB = 1'b1;
        dv = '{line(0) | line(42), line(2), line(2), line(2), line(2)};
        rv = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        nv = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        ev[0] = frozen; ev[0].ADL_ABL = 1'b0;
        ev[1] = frozen; ev[2] = frozen; ev[3] = frozen;
        ev[4] = idle(); ev[4].X_SB = 1'b1;
        for (int i = 0; i < 5; i++) begin
            decoder = dv[i]; RDY = rv[i]; _ready = nv[i];
            exp_q.push_back(ev[i]);
            @(posedge PHI0); @(negedge PHI0);
            want = exp_q.pop_front();
            checks++;
            if (o !== want) begin errors++; $display("FAIL rdy_hold[%0d]: got %h want %h", i, o, want); end
        end
        decoder = '0; RDY = 1'b1; _ready = 1'b0;
    endtask

    task automatic test_so_edge();
        out_t ev[3];
        ev[0] = idle(); ev[0].ONE_V = 1'b1;
        ev[1] = idle(); ev[1].ZERO_V = 1'b1; ev[1].AVR_V = 1'b1;
        ev[2] = ev[1];
        decoder = line(47) | line(56);
        SO = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(ev[i]);
            @(posedge PHI0); @(negedge PHI0);
            want = exp_q.pop_front();
            checks++;
            if (o !== want) begin errors++; $display("FAIL so_edge[%0d]: got %h want %h", i, o, want); end
        end
        decoder = '0;
        #2 RST = 1'b1;
        #1;
        checks++;
        if (o !== idle()) begin errors++; $display("FAIL so_reset_async: got %h want %h", o, idle()); end
        #1 RST = 1'b0;
        exp_q.push_back(ev[0]);
        @(posedge PHI0); @(negedge PHI0);
        want = exp_q.pop_front();
        checks++;
        if (o !== want) begin errors++; $display("FAIL so_after_reset: got %h want %h", o, want); end
        SO = 1'b0;
        exp_q.push_back(idle());
        @(posedge PHI0); @(negedge PHI0);
        want = exp_q.pop_front();
        checks++;
        if (o !== want) begin errors++; $display("FAIL so_low: got %h want %h", o, want); end
    endtask

    task automatic test_branch();
        int   lv[7];
        logic t0v[7], fwv[7], acv[7];
        out_t ev[7];
        lv  = '{58, -1, -1, 58, -1, 58, 58};
        t0v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        fwv = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        acv = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) ev[i] = idle();
        ev[0].BR2 = 1'b1;
        ev[1].ADH_PCH = 1'b1; ev[1].PCH_PCH = 1'b0;
        ev[3].BR2 = 1'b1;
        ev[6].BR2 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            decoder = (lv[i] >= 0) ? line(lv[i]) : '0;
            T0 = t0v[i]; BRFW = fwv[i]; ACRL2 = acv[i];
            exp_q.push_back(ev[i]);
            @(posedge PHI0); @(negedge PHI0);
            want = exp_q.pop_front();
            checks++;
            if (o !== want) begin errors++; $display("FAIL branch[%0d]: got %h want %h", i, o, want); end
        end
        #2 RST = 1'b1;
        #1;
        checks++;
        if (o !== idle()) begin errors++; $display("FAIL branch_reset_async: got %h want %h", o, idle()); end
        #1 RST = 1'b0;
        decoder = '0; T0 = 1'b0; BRFW = 1'b0; ACRL2 = 1'b1;
        exp_q.push_back(idle());
        @(posedge PHI0); @(negedge PHI0);
        want = exp_q.pop_front();
        checks++;
        if (o !== want) begin errors++; $display("FAIL branch_discard: got %h want %h", o, want); end
        BRFW = 1'b1; ACRL2 = 1'b0;
    endtask

    task automatic test_brk();
        dec_t dv[5];
        logic t5v[5], t6v[5], bv[5];
        out_t ev[5];
        dv  = '{line(57), line(57), line(57), '0, '0};
        t5v = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        t6v = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        bv  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) ev[i] = idle();
        ev[0].BRK5 = 1'b1; ev[1].BRK5 = 1'b1;
        ev[3].DL_ADL = 1'b1; ev[3].DL_ADH = 1'b1;
        for (int i = 0; i < 5; i++) begin
            decoder = dv[i]; T5 = t5v[i]; T6 = t6v[i]; BRK6E = bv[i];
            exp_q.push_back(ev[i]);
            @(posedge PHI0); @(negedge PHI0);
            want = exp_q.pop_front();
            checks++;
            if (o !== want) begin errors++; $display("FAIL brk[%0d]: got %h want %h", i, o, want); end
        end
    endtask

    task automatic test_decimal_carry();
        int   lv[6];
        logic dv[6], cv[6];
        out_t ev[6];
        lv = '{27, 27, 28, 27, 32, 26};
        dv = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        cv = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) ev[i] = idle();
        ev[0].SUMS = 1'b1; ev[0]._DAA = 1'b0;
        ev[1].SUMS = 1'b1;
        ev[2].SUMS = 1'b1; ev[2]._DSA = 1'b0;
        ev[3].SUMS = 1'b1; ev[3]._ADDC = 1'b0;
        ev[4]._ADDC = 1'b0;
        ev[5].SUMS = 1'b1;
        for (int i = 0; i < 6; i++) begin
            decoder = line(lv[i]); _D_OUT = dv[i]; _C_OUT = cv[i];
            exp_q.push_back(ev[i]);
            @(posedge PHI0); @(negedge PHI0);
            want = exp_q.pop_front();
            checks++;
            if (o !== want) begin errors++; $display("FAIL decimal[%0d]: got %h want %h", i, o, want); end
        end
        decoder = '0; _D_OUT = 1'b1; _C_OUT = 1'b1;
    endtask

    task automatic test_pc_paths();
        dec_t dv[5];
        logic t1v[5];
        out_t ev[5];
        dv  = '{line(35) | line(36), line(35) | line(36), line(33), line(34), '0};
        t1v = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) ev[i] = idle();
        ev[0].ADL_PCL = 1'b1; ev[0]._ADL_PCL = 1'b0; ev[0].PCL_PCL = 1'b0; ev[0].ADH_PCH = 1'b1; ev[0].PCH_PCH = 1'b0;
        ev[1].DL_DB = 1'b1;
        ev[2].PCL_DB = 1'b1; ev[2].PC_DB = 1'b1;
        ev[3].PCH_DB = 1'b1; ev[3].PC_DB = 1'b1;
        for (int i = 0; i < 5; i++) begin
            decoder = dv[i]; T1 = t1v[i];
            exp_q.push_back(ev[i]);
            @(posedge PHI0); @(negedge PHI0);
            want = exp_q.pop_front();
            checks++;
            if (o !== want) begin errors++; $display("FAIL pc_path[%0d]: got %h want %h", i, o, want); end
        end
    endtask

    initial begin
        RST = 1'b1; decoder = '0;
        {T0, T1, T5, T6} = '0;
        RDY = 1'b1; _ready = 1'b0;
        BRK6E = 1'b0; Z_ADL0 = 1'b0; SO = 1'b0; BRFW = 1'b1; ACRL2 = 1'b0;
        _C_OUT = 1'b1; _D_OUT = 1'b1;
        test_reset();
        test_mask();
        test_alu_priority();
        test_rdy_hold();
        test_so_edge();
        test_branch();
        test_brk();
        test_decimal_carry();
        test_pc_paths();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
